// File: rtl/ofifo_drain_ctrl_if.sv
// OFIFO pop / SRAM write bundle between the drain controller,
// the array output FIFO and the scratchpad write port.
interface ofifo_drain_ctrl_if #(
  parameter int ADDR_W = 11
);

  logic              ofifo_valid;
  logic              ofifo_rd;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_addr;

  modport master (
    input  ofifo_valid,
    output ofifo_rd,
    output sram_wen,
    output sram_addr
  );

  modport slave (
    output ofifo_valid,
    input  ofifo_rd,
    input  sram_wen,
    input  sram_addr
  );

endinterface

// File: rtl/ofifo_drain_ctrl.sv
// Drains one tile of ROWS output rows from the OFIFO into SRAM,
// one pop at a time, writing each row RD_LAT cycles after its pop.
module ofifo_drain_ctrl #(
  parameter int ROWS   = 8,
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 2,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  ofifo_drain_ctrl_if.master bus,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   rows_written
);

  localparam int HW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    HOLD,
    FLUSH,
    DONE
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] base_d;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  issued_d;
  logic [CNT_W-1:0]  written_q;
  logic [CNT_W-1:0]  written_d;
  logic [HW-1:0]     hold_q;
  logic [HW-1:0]     hold_d;
  logic [RD_LAT-1:0] sr_q;
  logic [RD_LAT-1:0] sr_d;

  logic rd;
  logic wen;
  logic hold_last;
  logic more_rows;
  logic all_written;

  assign hold_last   = (hold_q == HW'(RD_LAT - 1));
  assign more_rows   = (issued_q < CNT_W'(ROWS));
  assign all_written = (written_q == CNT_W'(ROWS));

  // Write strobe is the pop delayed by the OFIFO read latency.
  assign wen = sr_q[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.ofifo_valid) begin
          state_d = READ;
        end
      end
      READ: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (hold_last) begin
          state_d = more_rows ? WAIT : FLUSH;
        end
      end
      FLUSH: begin
        if (all_written) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rd   = 1'b0;
    busy = 1'b1;
    done = 1'b0;
    unique case (state_q)
      IDLE:    busy = 1'b0;
      READ:    rd   = 1'b1;
      DONE:    done = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  always_comb begin
    base_d    = base_q;
    issued_d  = issued_q;
    written_d = written_q;
    hold_d    = hold_q;
    sr_d      = RD_LAT'({sr_q, rd});
    if (wen) begin
      written_d = written_q + CNT_W'(1);
    end
    if (state_q == READ) begin
      issued_d = issued_q + CNT_W'(1);
      hold_d   = '0;
    end
    if (state_q == HOLD) begin
      hold_d = hold_q + HW'(1);
    end
    if (state_q == IDLE && start) begin
      base_d    = base_addr;
      issued_d  = '0;
      written_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q    <= '0;
      issued_q  <= '0;
      written_q <= '0;
      hold_q    <= '0;
      sr_q      <= '0;
    end else begin
      base_q    <= base_d;
      issued_q  <= issued_d;
      written_q <= written_d;
      hold_q    <= hold_d;
      sr_q      <= sr_d;
    end
  end

  assign bus.ofifo_rd  = rd;
  assign bus.sram_wen  = wen;
  assign bus.sram_addr = base_q + ADDR_W'(written_q);
  assign rows_written  = written_q;

endmodule
